// File: rtl/pipe_stage_reg.sv
// Parametrised falling-edge pipeline register chain with valid bits, stall/flush,
// bubble substitution, saturating stall counter and occupancy count.
module pipe_stage_reg #(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 1,
  parameter logic [WIDTH-1:0] RST_VALUE    = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
  parameter int               STALL_CNT_W  = 4,
  localparam int              OCC_W        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wena,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [OCC_W-1:0]       occupancy
);

  logic [WIDTH-1:0]       r_data [DEPTH];
  logic [DEPTH-1:0]       r_vld;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic [OCC_W-1:0]       w_occ;

  // Every register in this CPU updates on the falling clock edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= RST_VALUE;
      end
      r_vld       <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= BUBBLE_VALUE;
      end
      r_vld       <= '0;
      r_stall_cnt <= '0;
    end else if (wena) begin
      r_data[0] <= valid_in ? data_in : BUBBLE_VALUE;
      r_vld[0]  <= valid_in;
      for (int k = 1; k < DEPTH; k++) begin
        r_data[k] <= r_data[k-1];
        r_vld[k]  <= r_vld[k-1];
      end
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != {STALL_CNT_W{1'b1}}) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(r_vld[k]);
    end
  end

  assign data_out  = r_data[DEPTH-1];
  assign valid_out = r_vld[DEPTH-1];
  assign stall_cnt = r_stall_cnt;
  assign occupancy = w_occ;

endmodule
